// File: rtl/smem_mem_req_arb_pkg.sv
// Shared constants, tag layout and FSM encoding for the forward/backward
// memory request arbiter.
package smem_mem_req_arb_pkg;

  localparam int SMEM_ADDR_W     = 42;
  localparam int SMEM_READ_NUM_W = 9;

  // Tag layout is {src, kl, read_num}; src sits above kl, both above read_num.
  function automatic int tag_src_bit(input int read_num_w);
    return read_num_w + 1;
  endfunction

  function automatic int tag_kl_bit(input int read_num_w);
    return read_num_w;
  endfunction

  typedef enum logic {
    SRC_F = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_K = 2'd1,
    ST_SEND_L = 2'd2
  } arb_state_e;

endpackage

// File: rtl/smem_req_fifo.sv
// Per-requester request FIFO; a push into a full FIFO is accepted only if
// the same FIFO pops that cycle, otherwise it is dropped and flagged.
module smem_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; count and pointers
  // alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/smem_mem_req_arb.sv
// Arbitrates forward and backward occurrence requests onto one memory port,
// issuing each request as a k beat followed by an l beat.
module smem_mem_req_arb
  import smem_mem_req_arb_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ADDR_W         = SMEM_ADDR_W,
  parameter int READ_NUM_WIDTH = SMEM_READ_NUM_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      f_req_valid,
  input  logic [ADDR_W-1:0]         f_addr_k,
  input  logic [ADDR_W-1:0]         f_addr_l,
  input  logic [READ_NUM_WIDTH-1:0] f_read_num,
  input  logic                      b_req_valid,
  input  logic [ADDR_W-1:0]         b_addr_k,
  input  logic [ADDR_W-1:0]         b_addr_l,
  input  logic [READ_NUM_WIDTH-1:0] b_read_num,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [READ_NUM_WIDTH+1:0] mem_tag,
  output logic                      stall,
  output logic                      overflow
);

  localparam int ENTRY_W = 2 * ADDR_W + READ_NUM_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int TAG_SRC = tag_src_bit(READ_NUM_WIDTH);
  localparam int TAG_KL  = tag_kl_bit(READ_NUM_WIDTH);

  arb_state_e         state_q, state_d;
  src_e               grant_q, grant_d;
  logic               overflow_q;
  logic               pop_f, pop_b;
  logic               empty_f, empty_b, full_f, full_b, drop_f, drop_b;
  logic [CNT_W-1:0]   count_f, count_b;
  logic [ENTRY_W-1:0] head_f, head_b, head;
  logic               ne_f_after, ne_b_after;

  smem_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo_f (
    .clk     (clk),
    .rst     (rst),
    .push_i  (f_req_valid),
    .data_i  ({f_addr_k, f_addr_l, f_read_num}),
    .pop_i   (pop_f),
    .head_o  (head_f),
    .count_o (count_f),
    .full_o  (full_f),
    .empty_o (empty_f),
    .drop_o  (drop_f)
  );

  smem_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .push_i  (b_req_valid),
    .data_i  ({b_addr_k, b_addr_l, b_read_num}),
    .pop_i   (pop_b),
    .head_o  (head_b),
    .count_o (count_b),
    .full_o  (full_b),
    .empty_o (empty_b),
    .drop_o  (drop_b)
  );

  // Round-robin by request: on a tie the source not granted last wins.
  function automatic src_e pick(input logic ne_f, input logic ne_b, input src_e last);
    if (ne_f && ne_b) return (last == SRC_F) ? SRC_B : SRC_F;
    return ne_f ? SRC_F : SRC_B;
  endfunction

  // Occupancy once the granted head leaves; same-cycle pushes are not counted.
  assign ne_f_after = (grant_q == SRC_F) ? (count_f > CNT_W'(1)) : !empty_f;
  assign ne_b_after = (grant_q == SRC_B) ? (count_b > CNT_W'(1)) : !empty_b;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    pop_f   = 1'b0;
    pop_b   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_f || !empty_b) begin
          grant_d = pick(!empty_f, !empty_b, grant_q);
          state_d = ST_SEND_K;
        end
      end
      ST_SEND_K: begin
        if (mem_ready) state_d = ST_SEND_L;
      end
      ST_SEND_L: begin
        if (mem_ready) begin
          pop_f = (grant_q == SRC_F);
          pop_b = (grant_q == SRC_B);
          if (ne_f_after || ne_b_after) begin
            grant_d = pick(ne_f_after, ne_b_after, grant_q);
            state_d = ST_SEND_K;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= SRC_B;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      overflow_q <= overflow_q | drop_f | drop_b;
    end
  end

  assign head      = (grant_q == SRC_B) ? head_b : head_f;
  assign mem_valid = (state_q == ST_SEND_K) || (state_q == ST_SEND_L);
  assign mem_addr  = (state_q == ST_SEND_L) ? head[READ_NUM_WIDTH +: ADDR_W]
                                            : head[ENTRY_W-1 -: ADDR_W];
  assign stall     = (count_f >= CNT_W'(DEPTH - 1)) || (count_b >= CNT_W'(DEPTH - 1));
  assign overflow  = overflow_q;

  always_comb begin
    mem_tag                       = '0;
    mem_tag[TAG_SRC]              = grant_q;
    mem_tag[TAG_KL]               = (state_q == ST_SEND_L);
    mem_tag[READ_NUM_WIDTH-1:0]   = head[READ_NUM_WIDTH-1:0];
  end

endmodule

// File: tb/tb_smem_mem_req_arb.sv
// Directed bench for smem_mem_req_arb: expected beats queued at stimulus time,
// a negedge monitor pops and compares every accepted memory beat.
module tb_smem_mem_req_arb;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 42;
  localparam int RN_W   = 9;
  localparam int TAG_W  = RN_W + 2;

  logic              clk, rst;
  logic              f_req_valid, b_req_valid;
  logic [ADDR_W-1:0] f_addr_k, f_addr_l, b_addr_k, b_addr_l;
  logic [RN_W-1:0]   f_read_num, b_read_num;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [TAG_W-1:0]  mem_tag;
  logic              stall, overflow;

  smem_mem_req_arb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_NUM_WIDTH(RN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .f_req_valid (f_req_valid),
    .f_addr_k    (f_addr_k),
    .f_addr_l    (f_addr_l),
    .f_read_num  (f_read_num),
    .b_req_valid (b_req_valid),
    .b_addr_k    (b_addr_k),
    .b_addr_l    (b_addr_l),
    .b_read_num  (b_read_num),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_tag     (mem_tag),
    .stall       (stall),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } beat_t;

  beat_t exp_q[$];
  int    vectors;
  int    miscompares;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_req(input logic src, input logic [ADDR_W-1:0] k,
                            input logic [ADDR_W-1:0] l, input logic [RN_W-1:0] rn);
    beat_t b;
    b.addr = k; b.tag = {src, 1'b0, rn}; exp_q.push_back(b);
    b.addr = l; b.tag = {src, 1'b1, rn}; exp_q.push_back(b);
  endtask

  // Monitor: an accepted beat is valid & ready just before the rising edge.
  always @(negedge clk) begin
    if (rst && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got addr 0x%0h tag 0x%0h, expected no beat", mem_addr, mem_tag);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_addr", 64'(mem_addr), 64'(b.addr));
        check("beat_tag", 64'(mem_tag), 64'(b.tag));
      end
    end
  end

  // All driver tasks start and end 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] l, input logic [RN_W-1:0] rn);
    f_req_valid = 1'b1; f_addr_k = k; f_addr_l = l; f_read_num = rn;
  endtask

  task automatic drive_b(input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] l, input logic [RN_W-1:0] rn);
    b_req_valid = 1'b1; b_addr_k = k; b_addr_l = l; b_read_num = rn;
  endtask

  task automatic push_cycle();
    tick();
    f_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    f_req_valid = 1'b0;
    b_req_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mem_valid) && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(n < 200), 64'd1);
  endtask

  task automatic wait_send_l(input string name);
    int n = 0;
    while (!(mem_valid && mem_tag[RN_W]) && n < 20) begin
      tick();
      n++;
    end
    check(name, 64'(n < 20), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; mem_ready = 1'b0;
    f_req_valid = 1'b0; f_addr_k = '0; f_addr_l = '0; f_read_num = '0;
    b_req_valid = 1'b0; b_addr_k = '0; b_addr_l = '0; b_read_num = '0;
    repeat (3) tick();
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b1;
    tick();

    // Single forward request: one idle cycle after the push, then k and l.
    mem_ready = 1'b1;
    expect_req(1'b0, 42'h10, 42'h20, 9'd5);
    drive_f(42'h10, 42'h20, 9'd5);
    push_cycle();
    check("latency_idle", 64'(mem_valid), 64'd0);
    tick();
    check("latency_valid", 64'(mem_valid), 64'd1);
    check("latency_addr_k", 64'(mem_addr), 64'h10);
    wait_drain("single_drain");
    check("single_idle", 64'(mem_valid), 64'd0);

    // Simultaneous F/B pairs: F wins both ties from a fresh reset.
    do_reset();
    expect_req(1'b0, 42'h100, 42'h101, 9'd1);
    expect_req(1'b1, 42'h200, 42'h201, 9'd2);
    drive_f(42'h100, 42'h101, 9'd1);
    drive_b(42'h200, 42'h201, 9'd2);
    push_cycle();
    wait_drain("pair1_drain");
    expect_req(1'b0, 42'h110, 42'h111, 9'd3);
    expect_req(1'b1, 42'h210, 42'h211, 9'd4);
    drive_f(42'h110, 42'h111, 9'd3);
    drive_b(42'h210, 42'h211, 9'd4);
    push_cycle();
    wait_drain("pair2_drain");

    // Back-pressure in SEND_L holds the beat and the FIFO.
    expect_req(1'b0, 42'h300, 42'h301, 9'd7);
    drive_f(42'h300, 42'h301, 9'd7);
    push_cycle();
    wait_send_l("hold_reach_l");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 64'(mem_valid), 64'd1);
      check("hold_addr", 64'(mem_addr), 64'h301);
      check("hold_tag", 64'(mem_tag), 64'({1'b0, 1'b1, 9'd7}));
      check("hold_count", 64'(dut.u_fifo_f.count_o), 64'd1);
    end
    mem_ready = 1'b1;
    wait_drain("hold_drain");

    // Fill B with memory stalled: stall at 3, drop and sticky overflow at 5.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_req(1'b1, 42'(42'h400 + 2 * i), 42'(42'h401 + 2 * i), 9'(10 + i));
      drive_b(42'(42'h400 + 2 * i), 42'(42'h401 + 2 * i), 9'(10 + i));
      push_cycle();
      check("fill_stall", 64'(stall), 64'(i >= 2));
      check("fill_overflow", 64'(overflow), 64'(i == 4));
    end
    check("fill_count", 64'(dut.u_fifo_b.count_o), 64'd4);
    mem_ready = 1'b1;
    wait_drain("fill_drain");
    check("sticky_overflow", 64'(overflow), 64'd1);
    do_reset();
    check("overflow_cleared", 64'(overflow), 64'd0);

    // Full B FIFO: push coinciding with the SEND_L pop is accepted.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_req(1'b1, 42'(42'h500 + 2 * i), 42'(42'h501 + 2 * i), 9'(20 + i));
      drive_b(42'(42'h500 + 2 * i), 42'(42'h501 + 2 * i), 9'(20 + i));
      push_cycle();
    end
    check("full_count", 64'(dut.u_fifo_b.count_o), 64'd4);
    mem_ready = 1'b1;
    wait_send_l("full_reach_l");
    expect_req(1'b1, 42'h5f0, 42'h5f1, 9'd30);
    drive_b(42'h5f0, 42'h5f1, 9'd30);
    push_cycle();
    check("full_pushpop_count", 64'(dut.u_fifo_b.count_o), 64'd4);
    check("full_pushpop_overflow", 64'(overflow), 64'd0);
    wait_drain("full_drain");

    // Reset in SEND_K abandons the in-flight request.
    do_reset();
    mem_ready = 1'b0;
    drive_f(42'h600, 42'h601, 9'd40);
    push_cycle();
    for (int i = 0; i < 3; i++) begin
      drive_b(42'(42'h700 + i), 42'(42'h780 + i), 9'(41 + i));
      push_cycle();
    end
    check("pre_rst_stall", 64'(stall), 64'd1);
    check("pre_rst_valid", 64'(mem_valid), 64'd1);
    check("pre_rst_kl", 64'(mem_tag[RN_W]), 64'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_valid", 64'(mem_valid), 64'd0);
    check("mid_rst_stall", 64'(stall), 64'd0);
    check("mid_rst_count_f", 64'(dut.u_fifo_f.count_o), 64'd0);
    check("mid_rst_count_b", 64'(dut.u_fifo_b.count_o), 64'd0);
    rst = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_quiet", 64'(mem_valid), 64'd0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/smem_mem_req_arb.md
SMEM_MEM_REQ_ARB -- requirements
Module: smem_mem_req_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, per-requester queue depth in requests (power of two, >= 2).
REQ-002 SHALL have parameter ADDR_W, default 42, memory address width.
REQ-003 SHALL have parameter READ_NUM_WIDTH, default 9, read-slot index width.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port f_req_valid, input, 1, forward pipeline request strobe.
REQ-007 SHALL have ports f_addr_k and f_addr_l, input, ADDR_W each, forward k/l occurrence addresses.
REQ-008 SHALL have port f_read_num, input, READ_NUM_WIDTH, forward read slot.
REQ-009 SHALL have ports b_req_valid (1), b_addr_k (ADDR_W), b_addr_l (ADDR_W) and b_read_num (READ_NUM_WIDTH), all inputs, backward equivalents of REQ-006 to REQ-008.
REQ-010 SHALL have port mem_valid, output, 1, memory beat valid.
REQ-011 SHALL have port mem_ready, input, 1, memory accepts the beat.
REQ-012 SHALL have port mem_addr, output, ADDR_W, beat address.
REQ-013 SHALL have port mem_tag, output, READ_NUM_WIDTH+2, {src(1=B), kl(1=l), read_num}.
REQ-014 SHALL have port stall, output, 1, global pipeline stall.
REQ-015 SHALL have port overflow, output, 1, sticky drop flag.

Function
REQ-016 Each requester SHALL own a DEPTH-entry FIFO of {addr_k, addr_l, read_num} with an occupancy count of width log2(DEPTH)+1.
REQ-017 A push SHALL be accepted when req_valid=1 and (count<DEPTH, or the same FIFO pops that cycle).
REQ-018 A push that is not accepted SHALL be dropped, SHALL set overflow to 1, and SHALL leave the FIFO contents unchanged.
REQ-019 The FSM SHALL have three states: IDLE, SEND_K and SEND_L.
REQ-020 From IDLE, when either FIFO is non-empty, the FSM SHALL grant one FIFO and enter SEND_K on the next edge.
REQ-021 In SEND_K with mem_ready=1, the FSM SHALL go to SEND_L.
REQ-022 In SEND_L with mem_ready=1, the FSM SHALL pop the granted FIFO, then regrant and enter SEND_K if any FIFO is non-empty after the pop (no IDLE bubble), else enter IDLE.
REQ-023 The FSM SHALL hold state while mem_ready=0.
REQ-024 Grant SHALL be round-robin at request granularity: when both FIFOs are non-empty, the FIFO not granted last wins; when only one is non-empty, that FIFO wins.
REQ-025 mem_valid SHALL be 1 exactly in SEND_K and SEND_L.
REQ-026 mem_addr SHALL be the granted head's addr_k in SEND_K and its addr_l in SEND_L, stable while mem_ready=0.
REQ-027 mem_tag SHALL carry the granted source, kl=0 in SEND_K / kl=1 in SEND_L, and the head's read_num.
REQ-028 Latency: a push at edge E into empty FIFOs with the FSM in IDLE SHALL give mem_valid=1 in the cycle after E+1; the minimum is two beats per request.
REQ-029 stall SHALL be combinational: (count_f >= DEPTH-1) OR (count_b >= DEPTH-1). This reserves one slot for a request already in flight upstream.
REQ-030 A simultaneous push and pop on the same FIFO SHALL keep its count unchanged.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH.
REQ-032 When the FSM is in SEND_K or SEND_L, new pushes SHALL NOT change the granted source.

Reset
REQ-033 While rst=0 at an edge: FSM to IDLE, both counts and pointers to 0, last-grant to B (so F wins the first tie), overflow to 0.
REQ-034 During reset, mem_valid SHALL be 0 and stall SHALL be 0 from the following cycle.
REQ-035 Reset mid-transfer SHALL abandon the in-flight request with no further beats issued for it.
REQ-036 FIFO data storage SHALL NOT require reset.

Structure
REQ-037 Shared package SHALL hold ADDR_W, READ_NUM_WIDTH, the tag field layout (src/kl bit positions) and the FSM state encoding.
REQ-038 One sub-module, smem_req_fifo (parameterised width/depth, push/pop/count/full/empty), SHALL be instantiated twice.
REQ-039 The arbiter FSM SHALL live in the top module.

Verification
REQ-040 Single F push (addr_k=0x10, addr_l=0x20, read_num=5), mem_ready=1 -> beats 0x10 tag{0,0,5}, then 0x20 tag{0,1,5}, then IDLE.
REQ-041 F and B push in the same cycle, mem_ready=1 -> order F-k, F-l, B-k, B-l; a second simultaneous pair -> F first again, since round-robin alternates per request.
REQ-042 mem_ready=0 for 3 cycles during SEND_L -> mem_addr and mem_tag held constant, no pop, count unchanged.
REQ-043 mem_ready=0 with 3 B pushes -> stall=1 once count_b reaches 3; a 5th push (DEPTH=4) -> dropped, overflow=1 sticky until reset.
REQ-044 Full B FIFO with a SEND_L pop and a push in the same cycle -> push accepted, count stays 4, overflow stays 0.
REQ-045 Reset asserted during SEND_K -> next cycle mem_valid=0, stall=0, counts=0, and no l beat issued afterwards.
